// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: control levels,
// bus widths and the fetch FSM encoding.
package if_stage_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   typedef logic [5:0]  stall_bus_t;
   typedef logic [31:0] inst_addr_t;
   typedef logic [31:0] inst_t;

   // REQ: issue byte read, WAIT: byte outstanding, HOLD: instruction presented,
   // DRAIN: swallow a byte belonging to a fetch killed by a redirect.
   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_e;

   // Drop a returned byte into its little-endian lane of the partial word.
   function automatic logic [23:0] place_byte(input logic [23:0] buf_in,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
      logic [23:0] r;
      r = buf_in;
      case (lane)
         2'd0:    r[7:0]   = b;
         2'd1:    r[15:8]  = b;
         default: r[23:16] = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Byte-wide read channel between the fetch stage (master) and the memory
// controller (slave). One request may be outstanding at a time.
interface if_stage_if;
   import if_stage_pkg::*;

   logic       mem_req;
   inst_addr_t mem_addr;
   logic       mem_busy;
   logic       mem_valid;
   logic [7:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_busy,
      input  mem_valid,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_busy,
      output mem_valid,
      output mem_rdata
   );

endinterface

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, assembles one 32-bit instruction from four
// byte reads, and holds it for IF/ID. A redirect from EX kills any fetch in
// flight; a byte still owed by memory is drained before fetching again.
module if_stage
   import if_stage_pkg::*;
#(
   parameter inst_addr_t BOOT_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  stall_bus_t      stall,
   input  logic            branch_from_ex,
   input  inst_addr_t      branch_target,
   if_stage_if.master      mem,
   output logic            if_flag,
   output inst_addr_t      if_pc,
   output inst_t           if_inst
);

   fetch_state_e state_q;
   inst_addr_t   pc_q;
   logic [1:0]   k_q;
   logic [23:0]  buf_q;
   logic         if_flag_q;
   inst_addr_t   if_pc_q;
   inst_t        if_inst_q;

   // Only the IF/ID stop bit matters to this stage.
   logic         unused_stall_bits;
   assign unused_stall_bits = ^{stall[5:2], stall[0]};

   // A redirect suppresses the request so nothing is issued to the stale PC.
   assign mem.mem_req  = (state_q == ST_REQ) && !branch_from_ex;
   assign mem.mem_addr = pc_q + {30'b0, k_q};

   assign if_flag = if_flag_q;
   assign if_pc   = if_pc_q;
   assign if_inst = if_inst_q;

   // Fetch FSM: byte sequencing, redirect handling and the presented instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_REQ;
         pc_q      <= BOOT_PC;
         k_q       <= 2'd0;
         buf_q     <= 24'h0;
         if_flag_q <= DISABLE;
         if_pc_q   <= ZERO_WORD;
         if_inst_q <= ZERO_WORD;
      end else begin
         case (state_q)
            ST_REQ: begin
               if (branch_from_ex) begin
                  pc_q <= branch_target;
                  k_q  <= 2'd0;
               end else if (!mem.mem_busy) begin
                  state_q <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (branch_from_ex) begin
                  // Byte arriving with the redirect is dropped; otherwise
                  // it is still owed and must be drained.
                  pc_q    <= branch_target;
                  k_q     <= 2'd0;
                  state_q <= mem.mem_valid ? ST_REQ : ST_DRAIN;
               end else if (mem.mem_valid) begin
                  if (k_q == 2'd3) begin
                     if_inst_q <= {mem.mem_rdata, buf_q};
                     if_pc_q   <= pc_q;
                     if_flag_q <= ENABLE;
                     state_q   <= ST_HOLD;
                  end else begin
                     buf_q   <= place_byte(buf_q, k_q, mem.mem_rdata);
                     k_q     <= k_q + 2'd1;
                     state_q <= ST_REQ;
                  end
               end
            end

            ST_HOLD: begin
               if (branch_from_ex) begin
                  // IF/ID flushes on this edge, so the held word is abandoned.
                  if_flag_q <= DISABLE;
                  pc_q      <= branch_target;
                  k_q       <= 2'd0;
                  state_q   <= ST_REQ;
               end else if (stall[1] == NO_STOP) begin
                  if_flag_q <= DISABLE;
                  pc_q      <= pc_q + 32'd4;
                  k_q       <= 2'd0;
                  state_q   <= ST_REQ;
               end
            end

            ST_DRAIN: begin
               if (branch_from_ex) begin
                  pc_q <= branch_target;
                  k_q  <= 2'd0;
               end
               if (mem.mem_valid) begin
                  state_q <= ST_REQ;
               end
            end

            default: state_q <= ST_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage: a byte memory with random latency and
// back-pressure, random stalls, redirects and resets, checked against an
// instruction-level reference model.
module tb_if_stage;
   import if_stage_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   stall_bus_t stall;
   logic       branch_from_ex;
   inst_addr_t branch_target;
   logic       if_flag;
   inst_addr_t if_pc;
   inst_t      if_inst;

   if_stage_if mem_bus();

   if_stage #(.BOOT_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .branch_from_ex (branch_from_ex),
      .branch_target  (branch_target),
      .mem            (mem_bus),
      .if_flag        (if_flag),
      .if_pc          (if_pc),
      .if_inst        (if_inst)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_inst = 0;

   // stimulus knobs (percent probabilities, max extra memory latency)
   int p_busy, p_stall, p_branch, p_rst, max_lat;
   int force_rst;

   // memory controller model
   logic        mem_pend;
   logic [31:0] mem_pend_addr;
   int          mem_cnt;

   // reference model: instruction-level view of the fetch
   logic [31:0] m_pc;      // address of the instruction being fetched/held
   int          m_got;     // bytes of it received so far
   logic        m_flag;    // an instruction is being presented
   logic        m_out;     // memory owes us a byte
   logic        m_stale;   // that owed byte belongs to a killed fetch
   logic [31:0] m_ipc, m_inst;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [7:0] h;
      if (a == 32'd0) return 8'h13;
      if (a < 32'd4) return 8'h00;
      h = a[7:0] * 8'd37;
      return h ^ a[15:8] ^ a[31:24] ^ 8'h5A;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
   endfunction

   // One clock cycle: drive inputs, check combinational outputs, then update
   // the memory and reference models and check the registered outputs.
   task automatic step();
      logic pre_rst, pre_br, pre_stop, pre_busy, pre_valid, pre_req, accept, was_flag;
      logic [31:0] pre_tgt, pre_addr;

      @(negedge clk);
      rst = (force_rst > 0) || ($urandom_range(99) < p_rst);
      if (force_rst > 0) force_rst--;
      branch_from_ex = ($urandom_range(99) < p_branch);
      branch_target  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 + $urandom_range(7) : $urandom;
      stall          = 6'($urandom);
      stall[1]       = ($urandom_range(99) < p_stall);
      if (mem_pend && mem_cnt == 0) begin
         mem_bus.mem_valid = 1'b1;
         mem_bus.mem_rdata = mem_byte(mem_pend_addr);
      end else begin
         mem_bus.mem_valid = 1'b0;
         mem_bus.mem_rdata = 8'($urandom);
      end
      mem_bus.mem_busy = mem_pend ? 1'b1 : ($urandom_range(99) < p_busy);
      #1;
      pre_rst   = rst;
      pre_br    = branch_from_ex;
      pre_tgt   = branch_target;
      pre_stop  = stall[1];
      pre_busy  = mem_bus.mem_busy;
      pre_valid = mem_bus.mem_valid;
      pre_req   = mem_bus.mem_req;
      pre_addr  = mem_bus.mem_addr;

      if (!pre_rst) begin
         check_eq("mem_req", 32'(pre_req), 32'(!pre_br && !m_flag && !m_out));
         if (pre_req) check_eq("mem_addr", pre_addr, m_pc + 32'(m_got));
      end

      @(posedge clk);
      #1;
      accept = pre_req && !pre_busy;
      if (pre_rst) begin
         m_pc = 32'h0; m_got = 0; m_flag = 1'b0; m_out = 1'b0; m_stale = 1'b0;
         mem_pend = 1'b0;
         check_eq("rst_flag", 32'(if_flag), 32'd0);
         check_eq("rst_pc", if_pc, 32'h0);
         check_eq("rst_inst", if_inst, 32'h0);
      end else begin
         was_flag = m_flag;
         if (pre_valid) begin
            m_out = 1'b0;
            if (!m_stale && !pre_br) begin
               m_got++;
               if (m_got == 4) begin
                  m_flag = 1'b1;
                  m_ipc  = m_pc;
                  m_inst = mem_word(m_pc);
                  n_inst++;
                  $display("inst pc=%h inst=%h t=%0t", m_ipc, m_inst, $time);
               end
            end
            m_stale = 1'b0;
         end
         if (pre_br) begin
            if (m_out) m_stale = 1'b1;
            m_pc = pre_tgt; m_got = 0; m_flag = 1'b0;
         end else if (was_flag && !pre_stop) begin
            m_flag = 1'b0; m_pc = m_pc + 32'd4; m_got = 0;
         end
         if (accept) begin
            m_out = 1'b1; m_stale = 1'b0;
         end

         if (pre_valid) mem_pend = 1'b0;
         else if (mem_pend) mem_cnt--;
         if (accept) begin
            mem_pend      = 1'b1;
            mem_pend_addr = pre_addr;
            mem_cnt       = $urandom_range(max_lat);
         end

         check_eq("if_flag", 32'(if_flag), 32'(m_flag));
         if (m_flag) begin
            check_eq("if_pc", if_pc, m_ipc);
            check_eq("if_inst", if_inst, m_inst);
         end
      end
   endtask

   // per-segment knobs: busy, stall, branch, max latency, reset (percent)
   int seg_cfg [5][5] = '{
      '{ 0,  0, 0, 0, 0},
      '{30,  0, 0, 2, 0},
      '{ 0, 60, 0, 0, 0},
      '{20, 30, 8, 3, 0},
      '{25, 40, 5, 2, 1}
   };

   initial begin
      rst = 1'b1; stall = '0; branch_from_ex = 1'b0; branch_target = '0;
      mem_bus.mem_busy = 1'b0; mem_bus.mem_valid = 1'b0; mem_bus.mem_rdata = '0;
      mem_pend = 1'b0; mem_pend_addr = '0; mem_cnt = 0;
      m_pc = '0; m_got = 0; m_flag = 1'b0; m_out = 1'b0; m_stale = 1'b0;
      m_ipc = '0; m_inst = '0;
      p_busy = 0; p_stall = 0; p_branch = 0; p_rst = 0; max_lat = 0;

      // boot fetch with zero-wait memory: first instruction after 8 cycles
      force_rst = 2;
      repeat (2) step();
      for (int i = 1; i <= 9; i++) begin
         step();
         if (i == 7) check_eq("boot_flag_early", 32'(if_flag), 32'd0);
         if (i == 8) begin
            check_eq("boot_flag", 32'(if_flag), 32'd1);
            check_eq("boot_inst", if_inst, 32'h0000_0013);
            check_eq("boot_pc", if_pc, 32'h0);
         end
         if (i == 9) begin
            check_eq("next_req", 32'(mem_bus.mem_req), 32'd1);
            check_eq("next_addr", mem_bus.mem_addr, 32'h4);
         end
      end

      for (int s = 0; s < 5; s++) begin
         p_busy   = seg_cfg[s][0];
         p_stall  = seg_cfg[s][1];
         p_branch = seg_cfg[s][2];
         max_lat  = seg_cfg[s][3];
         p_rst    = seg_cfg[s][4];
         force_rst = 1;
         repeat (1500) step();
      end

      check_eq("progress", 32'(n_inst > 100), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
